// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: word type, initial hash values, round constants,
// FSM state encoding and word rotate helpers.
package sha1_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t H0_INIT = 32'h67452301;
    localparam word_t H1_INIT = 32'hEFCDAB89;
    localparam word_t H2_INIT = 32'h98BADCFE;
    localparam word_t H3_INIT = 32'h10325476;
    localparam word_t H4_INIT = 32'hC3D2E1F0;

    localparam word_t K0 = 32'h5A827999;
    localparam word_t K1 = 32'h6ED9EBA1;
    localparam word_t K2 = 32'h8F1BBCDC;
    localparam word_t K3 = 32'hCA62C1D6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUNDS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic word_t rotl1(input word_t x);
        return {x[30:0], x[31]};
    endfunction

    function automatic word_t rotl5(input word_t x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic word_t rotl30(input word_t x);
        return {x[1:0], x[31:2]};
    endfunction

endpackage

// File: rtl/sha1_w_mem.sv
// SHA-1 message schedule: 16-word sliding window. o_w is always W_t for the
// current round; each advance shifts the window and appends W_t+16.
module sha1_w_mem
    import sha1_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_advance,
    input  logic [511:0] i_chunk,
    output word_t        o_w
);

    word_t r_w [16];
    word_t w_new;

    // Next schedule word: W_t+16 = rotl1(W_t+13 ^ W_t+8 ^ W_t+2 ^ W_t)
    always_comb begin
        w_new = rotl1(r_w[13] ^ r_w[8] ^ r_w[2] ^ r_w[0]);
    end

    // Window register: load big-endian words from the chunk, or shift by one
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
        end else if (i_load) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_w[i] <= i_chunk[511 - 32*i -: 32];
            end
        end else if (i_advance) begin
            for (int unsigned i = 0; i < 15; i++) begin
                r_w[i] <= r_w[i+1];
            end
            r_w[15] <= w_new;
        end
    end

    assign o_w = r_w[0];

endmodule

// File: rtl/sha1_core.sv
// SHA-1 compression core: one 512-bit chunk per start, one round per clock,
// digest held in the H registers between chunks.
module sha1_core
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic [511:0] chunk,
    output logic         ready,
    output logic [159:0] out_digest,
    output logic         out_valid
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_start;
    logic       w_round_en;
    logic       w_done;

    logic [6:0] r_round;
    word_t      r_a, r_b, r_c, r_d, r_e;
    word_t      r_h [5];
    logic       r_ready;
    logic       r_valid;

    word_t      w_w;
    word_t      w_f;
    word_t      w_k;
    word_t      w_t;

    sha1_w_mem u_w_mem (
        .i_clk     (clk),
        .i_rst_n   (reset_n),
        .i_load    (w_start),
        .i_advance (w_round_en),
        .i_chunk   (chunk),
        .o_w       (w_w)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and per-state control strobes
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_round_en   = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (init || next) begin
                    w_start      = 1'b1;
                    w_next_state = ST_ROUNDS;
                end
            end
            ST_ROUNDS: begin
                w_round_en = 1'b1;
                if (r_round == 7'd79) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Round function: f and K selected by round group, T combined mod 2^32
    always_comb begin
        if (r_round < 7'd20) begin
            w_f = (r_b & r_c) | (~r_b & r_d);
            w_k = K0;
        end else if (r_round < 7'd40) begin
            w_f = r_b ^ r_c ^ r_d;
            w_k = K1;
        end else if (r_round < 7'd60) begin
            w_f = (r_b & r_c) | (r_b & r_d) | (r_c & r_d);
            w_k = K2;
        end else begin
            w_f = r_b ^ r_c ^ r_d;
            w_k = K3;
        end
        w_t = rotl5(r_a) + w_f + r_e + w_k + w_w;
    end

    // Datapath: working variables, hash state, round counter and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_round <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_e     <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                r_h[i] <= '0;
            end
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else if (w_start) begin
            r_round <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            if (init) begin
                r_h[0] <= H0_INIT;
                r_h[1] <= H1_INIT;
                r_h[2] <= H2_INIT;
                r_h[3] <= H3_INIT;
                r_h[4] <= H4_INIT;
                r_a    <= H0_INIT;
                r_b    <= H1_INIT;
                r_c    <= H2_INIT;
                r_d    <= H3_INIT;
                r_e    <= H4_INIT;
            end else begin
                r_a <= r_h[0];
                r_b <= r_h[1];
                r_c <= r_h[2];
                r_d <= r_h[3];
                r_e <= r_h[4];
            end
        end else if (w_round_en) begin
            r_e     <= r_d;
            r_d     <= r_c;
            r_c     <= rotl30(r_b);
            r_b     <= r_a;
            r_a     <= w_t;
            r_round <= r_round + 7'd1;
        end else if (w_done) begin
            r_h[0]  <= r_h[0] + r_a;
            r_h[1]  <= r_h[1] + r_b;
            r_h[2]  <= r_h[2] + r_c;
            r_h[3]  <= r_h[3] + r_d;
            r_h[4]  <= r_h[4] + r_e;
            r_ready <= 1'b1;
            r_valid <= 1'b1;
        end
    end

    assign ready      = r_ready;
    assign out_valid  = r_valid;
    assign out_digest = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4]};

endmodule

// File: tb/tb_sha1_core.sv
// Directed self-checking bench for sha1_core using known SHA-1 vectors and a
// queue of expected digests pushed at each start and popped on completion.
module tb_sha1_core;

    logic         clk;
    logic         reset_n;
    logic         init;
    logic         next;
    logic [511:0] chunk;
    logic         ready;
    logic [159:0] out_digest;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    logic [159:0] exp_q [$];

    localparam logic [511:0] CHUNK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] CHUNK_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] CHUNK_B2  = {{15{32'h0}}, 32'h000001C0};

    localparam logic [159:0] DIG_ABC = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] DIG_B1  = 160'hf4286818c37b27ae0408f581846771484a566572;
    localparam logic [159:0] DIG_B12 = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

    sha1_core dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .init       (init),
        .next       (next),
        .chunk      (chunk),
        .ready      (ready),
        .out_digest (out_digest),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] junk_chunk();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) begin
            v[32*i +: 32] = $urandom;
        end
        return v;
    endfunction

    // Drive a start pulse, record the expected digest, check the start edge effect
    task automatic start_op(input logic i_init, input logic i_next,
                            input logic [511:0] c, input logic [159:0] exp);
        @(negedge clk);
        init  = i_init;
        next  = i_next;
        chunk = c;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        init  = 1'b0;
        next  = 1'b0;
        chunk = junk_chunk();
        chk("start_ready", {159'b0, ready}, 160'd0);
        chk("start_valid", {159'b0, out_valid}, 160'd0);
    endtask

    // Wait for ready (bounded), scrambling chunk and optionally pulsing init mid-run
    task automatic wait_done(input string tag, input int pulse_at);
        int n;
        logic [159:0] exp;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            init  = (n == pulse_at);
            chunk = junk_chunk();
            @(posedge clk);
            #1;
            n++;
        end
        init = 1'b0;
        chk({tag, "_latency"}, 160'(n), 160'd81);
        if (exp_q.size() == 0) begin
            exp = '0;
            chk({tag, "_queue_empty"}, 160'd1, 160'd0);
        end else begin
            exp = exp_q.pop_front();
        end
        chk({tag, "_digest"}, out_digest, exp);
        chk({tag, "_valid"}, {159'b0, out_valid}, 160'd1);
        chk({tag, "_ready"}, {159'b0, ready}, 160'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        init    = 1'b0;
        next    = 1'b0;
        chunk   = '0;
        #12;
        chk("rst_ready", {159'b0, ready}, 160'd1);
        chk("rst_valid", {159'b0, out_valid}, 160'd0);
        chk("rst_digest", out_digest, 160'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single-block "abc"
        start_op(1'b1, 1'b0, CHUNK_ABC, DIG_ABC);
        wait_done("abc", -1);

        // Digest holds while idle
        repeat (3) @(posedge clk);
        #1;
        chk("abc_hold", out_digest, DIG_ABC);

        // Two-block message: init block 1, then next block 2
        start_op(1'b1, 1'b0, CHUNK_B1, DIG_B1);
        wait_done("blk1", -1);
        start_op(1'b0, 1'b1, CHUNK_B2, DIG_B12);
        wait_done("blk2", -1);

        // init pulsed during rounds has no effect
        start_op(1'b1, 1'b0, CHUNK_ABC, DIG_ABC);
        wait_done("abc_ign", 40);

        // init and next together from a prior digest: init wins
        start_op(1'b1, 1'b1, CHUNK_ABC, DIG_ABC);
        wait_done("both", -1);

        // Reset mid-rounds clears everything immediately
        start_op(1'b1, 1'b0, CHUNK_B1, DIG_B1);
        repeat (30) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", {159'b0, ready}, 160'd1);
        chk("midrst_valid", {159'b0, out_valid}, 160'd0);
        chk("midrst_digest", out_digest, 160'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;

        start_op(1'b1, 1'b0, CHUNK_ABC, DIG_ABC);
        wait_done("abc_post", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha1_core.md
SHA1_CORE -- requirements
Module: sha1

Interface
REQ-001 Parameters: none; the block is fixed-function SHA-1, 512-bit chunk in, 160-bit digest out.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 init  input  1  one-cycle pulse: start a new message; hash chunk from the standard initial H values.
REQ-006 next  input  1  one-cycle pulse: hash chunk as a continuation of the current H values.
REQ-007 chunk  input  512  padded message block; chunk[511:480] is W0, chunk[31:0] is W15 (big-endian words).
REQ-008 ready  output  1  high when idle and able to accept init/next.
REQ-009 out_digest  output  160  H0..H4 concatenated, H0 in [159:128].
REQ-010 out_valid  output  1  high when out_digest holds the result of the last completed chunk.

Function
REQ-011 FSM states: IDLE, ROUNDS, DONE.
REQ-012 IDLE: init or next sampled high -> ROUNDS; on that same edge ready and out_valid clear, chunk is latched internally, and round counter resets to 0.
REQ-013 On init start, H0..H4 load 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0; a..e load from these values.
REQ-014 On next start, H0..H4 keep their values; a..e load from H0..H4.
REQ-015 init and next high together: init wins.
REQ-016 init/next while not in IDLE: ignored; chunk may change freely after the start edge.
REQ-017 ROUNDS: one round per clock for t = 0..79; 80 edges total; after t = 79, go to DONE.
REQ-018 Round update: T = rotl5(a) + f_t + e + K_t + W_t (mod 2^32); e<=d, d<=c, c<=rotl30(b), b<=a, a<=T.
REQ-019 f/K by t: 0-19 Ch(b,c,d)=(b&c)|(~b&d), K 5A827999; 20-39 b^c^d, 6ED9EBA1; 40-59 Maj, 8F1BBCDC; 60-79 b^c^d, CA62C1D6.
REQ-020 Schedule: W0..W15 from latched chunk; W_t = rotl1(W_t-3 ^ W_t-8 ^ W_t-14 ^ W_t-16) for t >= 16, via a 16-word sliding window.
REQ-021 DONE (one cycle): Hi <= Hi + {a,b,c,d,e}i mod 2^32; ready and out_valid set; -> IDLE.
REQ-022 Latency: ready low for exactly 81 cycles after the start edge (1 load + 80 rounds); it rises on edge 82.
REQ-023 out_digest is driven directly from the H registers; it is stable while ready is high.

Reset
REQ-024 reset_n low (any time, including mid-ROUNDS): state IDLE, ready=1, out_valid=0, H0..H4=0, a..e=0, round counter=0, W window=0.
REQ-025 After reset release, the first chunk must start with init; next after reset hashes from H=0 (defined, not standard).

Structure
REQ-026 Shared package sha1_pkg: H initial constants, four K constants, FSM state enum, word-width constant.
REQ-027 One sub-module, sha1_w_mem: message schedule, with load (chunk), advance, and current W_t output.
REQ-028 Round function (f, K, T) is combinational logic in the top module; total RTL 120-400 lines.

Verification
REQ-029 Reset, then init with "abc" block (61626380 00..00 00000018) -> after ready, out_digest=a9993e364706816aba3e25717850c26c9cd0d89d, out_valid=1.
REQ-030 init with block 1 of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> f4286818c37b27ae0408f581846771484a566572; then next with block 2 (00..01C0) -> 84983e441c3bd26ebaae4aa1f95129e5e54670f1.
REQ-031 Timing: ready=0 on the edge sampling init, stays 0 for 81 cycles, ready/out_valid=1 on edge 82; chunk changed after the start edge does not affect the result.
REQ-032 init pulsed during ROUNDS -> ignored; "abc" digest unchanged; simultaneous init+next from a prior digest -> standard result (init wins).
REQ-033 reset_n asserted mid-ROUNDS -> ready=1, out_valid=0, out_digest=0 immediately; subsequent "abc" init -> correct digest.
